// File: rtl/env_update_scheduler_pkg.sv
// Shared types and constants for the environment-update scheduler slice.
package env_sched_pkg;

    localparam int unsigned VERTEX_WORLD_BITS = 32;
    localparam int unsigned COUNT_BITS        = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        DRAIN
    } env_sched_state_t;

    typedef struct packed {
        logic [VERTEX_WORLD_BITS-1:0] x;
        logic [VERTEX_WORLD_BITS-1:0] y;
    } vertex_t;

    // Saturating increment shared by all status counters.
    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/env_update_scheduler_if.sv
// Vertex-stream interface: start/valid/done from the environment manager
// and the valid/ready point stream towards the downstream consumer.
interface env_update_scheduler_if
    import env_sched_pkg::*;
#(
    parameter int unsigned WORLD_BITS = VERTEX_WORLD_BITS
) ();

    logic                  env_start_out;
    logic                  env_valid_in;
    logic [WORLD_BITS-1:0] env_x_in;
    logic [WORLD_BITS-1:0] env_y_in;
    logic                  env_done_in;
    logic                  pt_valid_out;
    logic [WORLD_BITS-1:0] pt_x_out;
    logic [WORLD_BITS-1:0] pt_y_out;
    logic                  pt_ready_in;

    // Scheduler side.
    modport master (
        output env_start_out,
        input  env_valid_in, env_x_in, env_y_in, env_done_in,
        output pt_valid_out, pt_x_out, pt_y_out,
        input  pt_ready_in
    );

    // Environment manager / consumer side.
    modport slave (
        input  env_start_out,
        output env_valid_in, env_x_in, env_y_in, env_done_in,
        input  pt_valid_out, pt_x_out, pt_y_out,
        output pt_ready_in
    );

endinterface

// File: rtl/env_update_scheduler_point_fifo.sv
// Show-ahead vertex FIFO with synchronous flush; a push is visible the
// cycle after it is written (no bypass).
module point_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/env_update_scheduler.sv
// Frame-rate sequencer: divides frame ticks, kicks the environment manager,
// buffers its vertex stream and forwards it, with overrun/overflow/hang guards.
module env_update_scheduler
    import env_sched_pkg::*;
#(
    parameter int unsigned WORLD_BITS     = VERTEX_WORLD_BITS,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FRAME_DIVIDE   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  enable_in,
    input  logic                  frame_tick_in,
    input  logic                  clear_flags_in,
    env_update_scheduler_if.master bus,
    output logic                  cycle_done_out,
    output logic                  busy_out,
    output logic [COUNT_BITS-1:0] vertex_count_out,
    output logic [COUNT_BITS-1:0] overrun_count_out,
    output logic                  overflow_out,
    output logic                  timeout_out
);

    localparam int unsigned TICK_W = $clog2(FRAME_DIVIDE + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_DIVIDE - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    env_sched_state_t          state;
    logic [TICK_W-1:0]         tick_cnt;
    logic [WDOG_W-1:0]         wdog;
    logic [COUNT_BITS-1:0]     accept_cnt;
    logic                      start_r;

    vertex_t                   in_vtx;
    vertex_t                   head_vtx;
    logic [WORLD_BITS-1:0]     head_x;
    logic [WORLD_BITS-1:0]     head_y;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic                      in_stream;
    logic                      wdog_expire;
    logic                      accept;
    logic                      drop;
    logic                      tick_busy;

    assign in_stream   = (state == STREAM);
    assign wdog_expire = in_stream && !bus.env_done_in && (wdog == WDOG_LAST);
    assign fifo_pop    = !fifo_empty && bus.pt_ready_in;
    assign fifo_push   = in_stream && bus.env_valid_in;
    assign accept      = fifo_push && (!fifo_full || fifo_pop);
    assign drop        = fifo_push && fifo_full && !fifo_pop;
    assign tick_busy   = frame_tick_in && (state != IDLE);

    assign in_vtx = '{x: bus.env_x_in, y: bus.env_y_in};
    assign head_x = head_vtx.x;
    assign head_y = head_vtx.y;

    // Head data is forced to zero while empty so reset leaves every output at 0.
    assign bus.pt_valid_out  = !fifo_empty;
    assign bus.pt_x_out      = fifo_empty ? '0 : head_x;
    assign bus.pt_y_out      = fifo_empty ? '0 : head_y;
    assign bus.env_start_out = start_r;
    assign busy_out          = (state != IDLE);

    point_fifo #(
        .WIDTH ($bits(vertex_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (wdog_expire),
        .din   (in_vtx),
        .dout  (head_vtx),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer FSM with divider, watchdog, counters and sticky flags.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            wdog              <= '0;
            accept_cnt        <= '0;
            start_r           <= 1'b0;
            cycle_done_out    <= 1'b0;
            vertex_count_out  <= '0;
            overrun_count_out <= '0;
            overflow_out      <= 1'b0;
            timeout_out       <= 1'b0;
        end else begin
            start_r        <= 1'b0;
            cycle_done_out <= 1'b0;

            if (drop)                overflow_out <= 1'b1;
            else if (clear_flags_in) overflow_out <= 1'b0;

            if (wdog_expire)         timeout_out <= 1'b1;
            else if (clear_flags_in) timeout_out <= 1'b0;

            // A lost tick coinciding with a clear restarts the count at one.
            if (tick_busy)
                overrun_count_out <= clear_flags_in ? COUNT_BITS'(1) : sat_inc(overrun_count_out);
            else if (clear_flags_in)
                overrun_count_out <= '0;

            case (state)
                IDLE: begin
                    if (frame_tick_in && enable_in) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            start_r  <= 1'b1;
                            state    <= START;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    accept_cnt <= '0;
                    wdog       <= '0;
                    state      <= STREAM;
                end
                STREAM: begin
                    if (accept) accept_cnt <= sat_inc(accept_cnt);
                    if (bus.env_done_in)   state <= DRAIN;
                    else if (wdog_expire)  state <= IDLE;
                    else                   wdog  <= wdog + 1'b1;
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        cycle_done_out   <= 1'b1;
                        vertex_count_out <= accept_cnt;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
